// File: rtl/pll_reset_sequencer.sv
// Reset and lock supervisor for the VGA pixel PLL, running in the reference clock domain.
// It drives the PLL reset and waits for lock to stay stable before releasing downstream reset.
// It re-sequences the PLL on lock loss or lock timeout, and goes to a sticky fault after
// the retry budget is spent.
module pll_reset_sequencer #(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic                             refclk,
    input  logic                             rst_n,
    input  logic                             pll_locked,
    input  logic                             relock_req,
    output logic                             pll_rst,
    output logic                             sys_rst_n,
    output logic                             ready,
    output logic                             fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
);

    localparam int unsigned MaxHoldLock = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES
                                                                       : LOCK_TIMEOUT;
    localparam int unsigned MaxCycles   = (MaxHoldLock > STABLE_CYCLES) ? MaxHoldLock
                                                                        : STABLE_CYCLES;
    localparam int unsigned CntW        = $clog2(MaxCycles);
    localparam int unsigned RetryW      = $clog2(MAX_RETRIES + 1);

    localparam logic [CntW-1:0]   HoldLast    = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0]   StableLast  = CntW'(STABLE_CYCLES - 1);
    localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStabilize,
        StRun,
        StFault
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              lock_meta_q;
    logic              locked_s;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            locked_s    <= lock_meta_q;
        end
    end

    // Next-state, shared counter and retry bookkeeping; every state entry clears the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        retry_d = retry_q;
        if (relock_req) begin
            state_d = StResetPll;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                StResetPll: begin
                    if (cnt_q == HoldLast) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end
                end
                StWaitLock: begin
                    if (locked_s) begin
                        state_d = StStabilize;
                        cnt_d   = '0;
                    end else if (cnt_q == TimeoutLast) begin
                        cnt_d = '0;
                        if (retry_q == RetryMax) begin
                            state_d = StFault;
                        end else begin
                            state_d = StResetPll;
                            retry_d = retry_q + RetryW'(1);
                        end
                    end
                end
                StStabilize: begin
                    if (!locked_s) begin
                        // Lock dropped before the window filled: fresh timeout, no retry spent.
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else if (cnt_q == StableLast) begin
                        state_d = StRun;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                StRun: begin
                    cnt_d = '0;
                    if (!locked_s) begin
                        state_d = StResetPll;
                    end
                end
                StFault: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = StResetPll;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State register with outputs registered from the next state, so they switch on entry.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q   <= StResetPll;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst   <= (state_d == StResetPll);
            sys_rst_n <= (state_d == StRun);
            ready     <= (state_d == StRun);
            fault     <= (state_d == StFault);
        end
    end

    assign retry_count = retry_q;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset and lock supervisor for the VGA pixel PLL. Runs in the 50 MHz reference domain and drives the PLL's active-high `rst` input. It watches the PLL `locked` output, requires lock to stay stable before releasing the pixel-domain reset, and re-sequences the PLL when lock is lost or never achieved. After a bounded number of failed attempts it raises a sticky fault.

## Interface
- `HOLD_CYCLES`, 16: refclk cycles `pll_rst` is held high per reset attempt (≥2).
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before an attempt is declared failed (1 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release.
- `MAX_RETRIES`, 3: re-attempts after the first before entering FAULT.
- `refclk`  in  1  50 MHz reference clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `pll_locked`  in  1  PLL `locked`; asynchronous, synchronized internally.
- `relock_req`  in  1  single-cycle request to restart sequencing; also clears FAULT.
- `pll_rst`  out  1  active-high reset to the PLL.
- `sys_rst_n`  out  1  active-low reset for downstream VGA logic; the consumer re-synchronizes it to the pixel clock.
- `ready`  out  1  high only in RUN.
- `fault`  out  1  high only in FAULT.
- `retry_count`  out  $clog2(MAX_RETRIES+1)  failed attempts in the current sequence.

## Operation
- `pll_locked` passes through a 2-flop synchronizer, giving `locked_s`. The synchronizer resets to 0.
- One shared cycle counter, width $clog2 of the largest of HOLD_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES. It clears on every state entry.
- All outputs are Moore decodes of the registered state and change on the edge that enters the state.
- Output values by state (`pll_rst` / `sys_rst_n` / `ready` / `fault`):
  - RESET_PLL: 1/0/0/0
  - WAIT_LOCK: 0/0/0/0
  - STABILIZE: 0/0/0/0
  - RUN: 0/1/1/0
  - FAULT: 0/0/0/1
- Reset (`rst_n`=0 at an edge): state RESET_PLL, counter 0, `retry_count` 0, synchronizer 0. The output values are those of RESET_PLL. `rst_n` has the highest priority in every state, including mid-sequence.
- RESET_PLL: count up. When the counter reaches HOLD_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - `locked_s`=1 → STABILIZE.
  - Otherwise, when the counter reaches LOCK_TIMEOUT-1: if `retry_count`==MAX_RETRIES, go to FAULT; else increment `retry_count` and go to RESET_PLL.
- STABILIZE:
  - `locked_s`=0 → WAIT_LOCK, with no retry increment and a fresh timeout.
  - Counter reaches STABLE_CYCLES-1 with `locked_s`=1 → RUN, and `retry_count` clears to 0.
- RUN: `locked_s`=0 → RESET_PLL, which drops `sys_rst_n` immediately. `retry_count` stays 0, so a fresh budget starts.
- FAULT: holds indefinitely. `retry_count` holds at MAX_RETRIES. `pll_rst` stays low.
- `relock_req`=1 in any state → RESET_PLL with the counter and `retry_count` cleared.
  - It takes priority over lock/timeout transitions in the same cycle.
  - In RESET_PLL it restarts the hold count.
- `retry_count` saturates and never wraps.

## Timing
- `rst_n` release → `pll_rst` high for exactly HOLD_CYCLES cycles.
- `pll_locked` rising, with the PLL held stable, → `sys_rst_n`/`ready` rise STABLE_CYCLES+3 edges later (2 sync, 1 WAIT_LOCK decision, STABLE_CYCLES count).
- `pll_locked` falling in RUN → `sys_rst_n` low and `pll_rst` high 3 edges later.
- No lock ever → FAULT after (MAX_RETRIES+1)×(HOLD_CYCLES+LOCK_TIMEOUT) cycles from reset release.
- `relock_req` → `pll_rst` high on the next edge.
- Lock glitches shorter than one refclk cycle may be missed. This is acceptable because the stability window filters what is seen.

## Test plan
Bench parameters: HOLD_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=2.

1. Nominal lock: release `rst_n`, raise `pll_locked` 20 cycles later and hold it.
   - Required: `pll_rst` high for exactly 4 cycles.
   - Required: `sys_rst_n`=`ready`=1 exactly 11 edges after the `pll_locked` rise.
   - Required: `retry_count`=0.
2. Glitch during STABILIZE: drop `pll_locked` for 3 cycles at stable count 5, then restore it.
   - Required: return to WAIT_LOCK with no `pll_rst` pulse and `retry_count` still 0.
   - Required: RUN 11 edges after the restore.
3. Never lock.
   - Required: `pll_rst` pulses of 4 cycles occurring 104 cycles apart.
   - Required: `retry_count` steps 1 then 2.
   - Required: `fault`=1 at cycle 312 from reset release, `pll_rst`=0, and the state holds there.
4. Loss of lock in RUN: deassert `pll_locked`.
   - Required: `sys_rst_n`=0, `ready`=0 and `pll_rst`=1 three edges later.
   - Then reassert `pll_locked` → required: RUN again with `retry_count`=0.
5. Recovery from FAULT: pulse `relock_req` for one cycle.
   - Required: `fault`=0, `pll_rst`=1 and `retry_count`=0 on the next edge.
   - Then lock → required: normal RUN.
6. Reset and relock mid-operation:
   - Assert `rst_n`=0 during STABILIZE → required: next edge gives `pll_rst`=1, `sys_rst_n`=0, `retry_count`=0.
   - `relock_req` coinciding with the WAIT_LOCK timeout → required: RESET_PLL with `retry_count` 0, not incremented.
